// File: rtl/panel_pkg.sv
// Constants and state encoding shared by the panel write arbiter and the panel driver.
package panel_pkg;
  localparam int PANEL_PIXELS = 4096;
  localparam int PANEL_ADDR_W = 16;
  localparam int PIXEL_W      = 24;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_FILL = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         gnt_idx,
  output logic               any
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = 3'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/panel_write_arbiter.sv
// Shares the panel write port among NUM_REQ producers and a full-frame fill engine.
//   state   | meaning
//   ST_ARB  | round-robin grant of requesters, one write per accept
//   ST_FILL | streaming latched colour to every pixel, requesters held off
module panel_write_arbiter
  import panel_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CHAINED = 1
) (
  input  logic                          ctrl_clk,
  input  logic                          ctrl_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [PANEL_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [PIXEL_W*NUM_REQ-1:0]    req_wdat,
  input  logic                          fill_start,
  input  logic [PIXEL_W-1:0]            fill_color,
  output logic                          fill_busy,
  output logic                          oob_err,
  output logic                          ctrl_en,
  output logic [PANEL_ADDR_W-1:0]       ctrl_addr,
  output logic [PIXEL_W-1:0]            ctrl_wdat,
  output logic [2:0]                    grant_id
);

  localparam int                     FRAME_INT = CHAINED * PANEL_PIXELS;
  localparam int                     CNT_W     = $clog2(FRAME_INT);
  localparam logic [PANEL_ADDR_W:0]  FRAME_PIX = (PANEL_ADDR_W+1)'(FRAME_INT);
  localparam logic [CNT_W-1:0]       FILL_LAST = CNT_W'(FRAME_INT - 1);

  arb_state_e               state;
  logic [2:0]               rr_ptr;
  logic [CNT_W-1:0]         fill_cnt;
  logic [PIXEL_W-1:0]       fill_color_q;

  logic [NUM_REQ-1:0]       gnt;
  logic [2:0]               gnt_idx;
  logic                     gnt_any;
  logic                     arb_go;
  logic                     accept;
  logic [PANEL_ADDR_W-1:0]  sel_addr;
  logic [PIXEL_W-1:0]       sel_wdat;
  logic                     oob_hit;
  logic [2:0]               ptr_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // A fill request in ARB pre-empts any simultaneous grant.
  assign arb_go    = (state == ST_ARB) && !fill_start && !ctrl_rst;
  assign accept    = gnt_any && arb_go;
  assign req_ready = arb_go ? gnt : '0;

  always_comb begin
    sel_addr = '0;
    sel_wdat = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr = req_addr[PANEL_ADDR_W*k +: PANEL_ADDR_W];
        sel_wdat = req_wdat[PIXEL_W*k +: PIXEL_W];
      end
    end
  end

  assign oob_hit  = {1'b0, sel_addr} >= FRAME_PIX;
  assign ptr_next = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;

  always_ff @(posedge ctrl_clk) begin
    if (ctrl_rst) begin
      state        <= ST_ARB;
      rr_ptr       <= '0;
      fill_cnt     <= '0;
      fill_color_q <= '0;
      fill_busy    <= 1'b0;
      oob_err      <= 1'b0;
      ctrl_en      <= 1'b0;
      ctrl_addr    <= '0;
      ctrl_wdat    <= '0;
      grant_id     <= '0;
    end else begin
      ctrl_en <= 1'b0;
      case (state)
        ST_ARB: begin
          if (fill_start) begin
            fill_color_q <= fill_color;
            fill_cnt     <= '0;
            fill_busy    <= 1'b1;
            state        <= ST_FILL;
          end else if (accept) begin
            rr_ptr <= ptr_next;
            if (oob_hit) begin
              oob_err <= 1'b1;
            end else begin
              ctrl_en   <= 1'b1;
              ctrl_addr <= sel_addr;
              ctrl_wdat <= sel_wdat;
              grant_id  <= gnt_idx;
            end
          end
        end
        ST_FILL: begin
          ctrl_en   <= 1'b1;
          ctrl_addr <= PANEL_ADDR_W'(fill_cnt);
          ctrl_wdat <= fill_color_q;
          grant_id  <= '0;
          // Leaving on the last write lets requesters win in the cycle it appears.
          if (fill_cnt == FILL_LAST) begin
            fill_busy <= 1'b0;
            state     <= ST_ARB;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_write_arbiter.sv
// Directed bench for panel_write_arbiter with NUM_REQ=2, CHAINED=1.
module tb_panel_write_arbiter;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_addr;
  logic [47:0] req_wdat;
  logic        fill_start;
  logic [23:0] fill_color;
  logic        fill_busy;
  logic        oob_err;
  logic        ctrl_en;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic [2:0]  grant_id;

  int checks   = 0;
  int failures = 0;

  panel_write_arbiter #(.NUM_REQ(2), .CHAINED(1)) dut (
    .ctrl_clk   (ctrl_clk),
    .ctrl_rst   (ctrl_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdat   (req_wdat),
    .fill_start (fill_start),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .oob_err    (oob_err),
    .ctrl_en    (ctrl_en),
    .ctrl_addr  (ctrl_addr),
    .ctrl_wdat  (ctrl_wdat),
    .grant_id   (grant_id)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ctrl_clk);
    #1;
  endtask

  initial begin
    int bad_en, bad_addr, bad_dat, bad_busy, bad_rdy;
    bit found;

    // Reset with every input active
    ctrl_rst   = 1'b1;
    req_valid  = 2'b11;
    req_addr   = {16'h0020, 16'h0010};
    req_wdat   = {24'hBB0002, 24'hAA0001};
    fill_start = 1'b1;
    fill_color = 24'h123456;
    #1;
    chk("rst_ready_comb", 32'(req_ready), 32'h0);
    repeat (3) tick();
    chk("rst_en",    32'(ctrl_en),   32'h0);
    chk("rst_addr",  32'(ctrl_addr), 32'h0);
    chk("rst_wdat",  32'(ctrl_wdat), 32'h0);
    chk("rst_gid",   32'(grant_id),  32'h0);
    chk("rst_busy",  32'(fill_busy), 32'h0);
    chk("rst_oob",   32'(oob_err),   32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    ctrl_rst   = 1'b0;
    fill_start = 1'b0;
    req_valid  = 2'b00;
    tick();
    chk("idle_en", 32'(ctrl_en), 32'h0);

    // Fairness: both valid, grants alternate 0,1,0,1...
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("fair_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("fair_en",   32'(ctrl_en),   32'h1);
      chk("fair_addr", 32'(ctrl_addr), (i % 2 == 0) ? 32'h0010 : 32'h0020);
      chk("fair_wdat", 32'(ctrl_wdat), (i % 2 == 0) ? 32'hAA0001 : 32'hBB0002);
      chk("fair_gid",  32'(grant_id),  (i % 2 == 0) ? 32'h0 : 32'h1);
    end
    req_valid = 2'b00;
    tick();
    chk("fair_stop_en", 32'(ctrl_en), 32'h0);

    // Out of range: accepted, no write, sticky flag
    req_valid = 2'b01;
    req_addr  = {16'h0020, 16'h1000};
    #1;
    chk("oob_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    chk("oob_no_en", 32'(ctrl_en), 32'h0);
    chk("oob_flag",  32'(oob_err), 32'h1);
    req_valid = 2'b01;
    req_addr  = {16'h0020, 16'h0123};
    #1;
    chk("oob_next_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    chk("oob_next_en",   32'(ctrl_en),   32'h1);
    chk("oob_next_addr", 32'(ctrl_addr), 32'h0123);
    tick();
    chk("oob_sticky", 32'(oob_err), 32'h1);

    // Full fill started together with requests; rr_ptr is 1 here
    req_addr   = {16'h0006, 16'h0005};
    req_valid  = 2'b11;
    fill_start = 1'b1;
    fill_color = 24'h3F0000;
    #1;
    chk("fill_start_ready", 32'(req_ready), 32'h0);
    tick();
    fill_start = 1'b0;
    fill_color = 24'h000000;
    chk("fill_busy_rise", 32'(fill_busy), 32'h1);
    chk("fill_n1_en",     32'(ctrl_en),   32'h0);
    #1;
    chk("fill_n1_ready",  32'(req_ready), 32'h0);
    bad_en = 0; bad_addr = 0; bad_dat = 0; bad_busy = 0; bad_rdy = 0;
    for (int k = 0; k < 4096; k++) begin
      tick();
      if (k == 10) fill_start = 1'b1;
      if (k == 11) fill_start = 1'b0;
      #1;
      if (ctrl_en !== 1'b1) bad_en++;
      if (ctrl_addr !== 16'(k)) bad_addr++;
      if (ctrl_wdat !== 24'h3F0000 || grant_id !== 3'd0) bad_dat++;
      if (fill_busy !== (k < 4095)) bad_busy++;
      if (req_ready !== ((k == 4095) ? 2'b10 : 2'b00)) bad_rdy++;
    end
    chk("fill_en_errs",   32'(bad_en),   32'h0);
    chk("fill_addr_errs", 32'(bad_addr), 32'h0);
    chk("fill_data_errs", 32'(bad_dat),  32'h0);
    chk("fill_busy_errs", 32'(bad_busy), 32'h0);
    chk("fill_rdy_errs",  32'(bad_rdy),  32'h0);
    chk("fill_last_addr", 32'(ctrl_addr), 32'h0FFF);
    tick();
    chk("post_fill_en",   32'(ctrl_en),   32'h1);
    chk("post_fill_addr", 32'(ctrl_addr), 32'h0006);
    chk("post_fill_gid",  32'(grant_id),  32'h1);
    tick();
    req_valid = 2'b00;
    chk("post_fill2_addr", 32'(ctrl_addr), 32'h0005);
    chk("post_fill2_gid",  32'(grant_id),  32'h0);
    tick();

    // Reset during a fill, at address 100
    fill_start = 1'b1;
    fill_color = 24'h00FF00;
    tick();
    fill_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      if (ctrl_en === 1'b1 && ctrl_addr === 16'd100) found = 1'b1;
    end
    chk("midfill_reached_100", 32'(found), 32'h1);
    ctrl_rst = 1'b1;
    tick();
    chk("midfill_rst_en",   32'(ctrl_en),   32'h0);
    chk("midfill_rst_busy", 32'(fill_busy), 32'h0);
    ctrl_rst  = 1'b0;
    req_valid = 2'b10;
    req_addr  = {16'h0042, 16'h0005};
    #1;
    chk("midfill_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    chk("midfill_en",   32'(ctrl_en),   32'h1);
    chk("midfill_addr", 32'(ctrl_addr), 32'h0042);
    chk("midfill_gid",  32'(grant_id),  32'h1);
    chk("midfill_oob",  32'(oob_err),   32'h0);
    tick();
    chk("midfill_quiet", 32'(ctrl_en), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/panel_write_arbiter.md
# panel_write_arbiter

Round-robin write scheduler for the LED panel frame buffer's `ctrl_*` write port. It shares that single port among `NUM_REQ` pixel producers, such as the UART loader and the drawing engine, and adds a built-in full-frame fill engine for screen clears. It lives entirely in the `ctrl_clk` domain. Its `ctrl_en`/`ctrl_addr`/`ctrl_wdat` outputs connect directly to the panel driver's write port.

## Interface

**Parameters**
- `NUM_REQ`, default 2: number of requesters; legal range 1..8.
- `CHAINED`, default 1: number of panels in the chain. Frame size is `CHAINED*4096` pixels.

**Ports**
- `ctrl_clk` in 1: sole clock.
- `ctrl_rst` in 1: reset, synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester write request.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit high per cycle.
- `req_addr` in `16*NUM_REQ`: packed pixel addresses; requester i occupies bits [16i+15:16i].
- `req_wdat` in `24*NUM_REQ`: packed colours in [R][G][B] byte order.
- `fill_start` in 1: single-cycle pulse that starts a full-frame fill.
- `fill_color` in 24: fill colour; sampled in the same cycle as `fill_start`.
- `fill_busy` out 1: high while the fill is in progress.
- `oob_err` out 1: sticky flag; set when an accepted address is ≥ `CHAINED*4096`.
- `ctrl_en` out 1: write strobe to the panel.
- `ctrl_addr` out 16: write address to the panel.
- `ctrl_wdat` out 24: write data to the panel.
- `grant_id` out 3: index of the requester behind the current `ctrl_en`; 0 during fill.

## Operation

- **States:** ARB and FILL. Reset enters ARB.
- **Accept rule:** a transfer happens when `req_valid[i] & req_ready[i]` are both high. Requester i holds its addr/wdat stable until accepted.
- **ARB state, no `fill_start`:**
  - A combinational round-robin grant selects the first valid requester at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - `req_ready` is one-hot on that requester, or all zero if none is valid. `req_ready` depends combinationally on `req_valid`.
  - On acceptance of requester i, `rr_ptr` becomes (i+1) mod `NUM_REQ`.
- **ARB state, `fill_start` high:**
  - `req_ready` is all zero that cycle; fill has priority over a simultaneous request.
  - `fill_color` is latched, the fill counter is cleared to 0, and the next state is FILL.
- **FILL state:**
  - One write per cycle: address = counter, data = latched colour.
  - After writing address `CHAINED*4096-1`, return to ARB.
  - `req_ready` stays 0 throughout. `fill_start` is ignored. `rr_ptr` is unchanged.
- **Out-of-range address:** the request is still accepted, so the requester never stalls, but no write is issued (`ctrl_en` stays 0) and `oob_err` is set. Only reset clears `oob_err`.
- **Throughput:** at most one write per cycle. No requester waits more than `NUM_REQ-1` grants while valid, excluding fill time.

## Timing

- **Reset values:** `ctrl_en`=0, `ctrl_addr`=0, `ctrl_wdat`=0, `grant_id`=0, `fill_busy`=0, `oob_err`=0, `rr_ptr`=0, state=ARB. `req_ready`=0 during the reset cycle.
- **Write latency:** `ctrl_*` are registered. A handshake in cycle N produces `ctrl_en`=1 with its addr/wdat in cycle N+1. `ctrl_en` is 1 for exactly one cycle per write.
- **Fill timing:**
  - `fill_start` in cycle N: `fill_busy` rises in N+1 and the first fill write (addr 0) appears in N+2.
  - The last fill write (addr `CHAINED*4096-1`) appears in N+1+`CHAINED*4096`. `fill_busy` falls in that same cycle.
  - Requesters become grantable in the cycle the last fill write appears.
- **Back-to-back:** continuous valid from one requester produces writes on consecutive cycles. With `NUM_REQ`=2 and both valid, grants alternate every cycle.
- **Reset mid-fill:** the fill is aborted and no further fill writes occur. `ctrl_en`=0 in the cycle after `ctrl_rst` is sampled.
- **Width rules:**
  - Fill counter is `log2(CHAINED*4096)` bits, zero-extended to 16 bits.
  - The range check compares the full 16-bit address.
  - `grant_id` is 3 bits wide regardless of `NUM_REQ`.

## Structure

- **Shared package `panel_pkg`:**
  - `PANEL_PIXELS` (4096), `PANEL_ADDR_W` (16), `PIXEL_W` (24).
  - ARB/FILL state encoding.
  - The panel driver uses the same constants.
- **Sub-module `rr_arbiter`:**
  - Parameterised `NUM_REQ`.
  - Inputs: `req` vector, `ptr`.
  - Outputs: one-hot `gnt`, binary `gnt_idx`, `any`.
  - Purely combinational. `rr_ptr` update stays in the parent.
- **Parent contents:** state register, fill counter, colour latch, output registers, `oob_err`.

## Test plan

- **Reset:** hold `ctrl_rst` for 3 cycles with all inputs active → every output at its reset value, `req_ready`=0.
- **Fairness:** `NUM_REQ`=2, both valid continuously, addr0=0x0010, addr1=0x0020 → `ctrl_addr` alternates 0x0010, 0x0020, … with `grant_id` 0,1,0,1, `ctrl_en` high every cycle, each write one cycle after its handshake.
- **Full fill:** `fill_start` with `fill_color`=0x3F0000, `CHAINED`=1 → exactly 4096 writes, addr 0..0x0FFF, data 0x3F0000. `fill_busy` high for 4096 cycles. Requester 0 held valid sees `req_ready`=0 until the last fill write.
- **Simultaneous start:** `fill_start` and `req_valid[1]` in the same cycle → no grant that cycle, fill proceeds. Requester 1 is then written after the fill ends, in the cycle following the last fill write.
- **Out of range:** request addr=0x1000 with `CHAINED`=1 → `req_ready`=1, no `ctrl_en` the next cycle, `oob_err`=1 sticky until reset. A following valid request writes normally.
- **Reset mid-fill:** assert `ctrl_rst` at fill address 100 → no write to address 101. After release, a new request is granted immediately.
